// File: rtl/dcache_pkg.sv
// dcache_pkg
// Shared constants and types for the data-cache lookup/refill path.
//   - Address field widths and slice positions (tag/set/word).
//   - Line geometry (words per line, number of sets).
//   - Miss-controller state encoding.
//   - Small helpers to pull fields out of a byte address.
package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int TAG_W      = 13;
  localparam int SET_W      = 7;
  localparam int WORD_W     = 3;

  localparam int TAG_LSB    = 12;
  localparam int SET_LSB    = 5;
  localparam int WORD_LSB   = 2;

  localparam int LINE_WORDS = 8;
  localparam int NUM_SETS   = 1 << SET_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_MISS_REQ = 3'd2,
    ST_FILL     = 3'd3,
    ST_TAG_WR   = 3'd4
  } miss_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[TAG_LSB +: TAG_W];
  endfunction

  function automatic logic [SET_W-1:0] addr_set(input logic [ADDR_W-1:0] addr);
    return addr[SET_LSB +: SET_W];
  endfunction

  // Line-aligned fetch address: clear the word and byte offset bits.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:SET_LSB], {SET_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/lru_bits.sv
// lru_bits
// One replacement bit per set for the 2-way cache. The stored bit names the
// way to evict next (0 = way 0, 1 = way 1).
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears all bits)
//   rd_set, rd_bit  combinational read port indexed by set
//   we, wr_set,     single write port, takes effect on the next clock edge
//   wr_bit
module lru_bits
  import dcache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SET_W-1:0] rd_set,
  output logic             rd_bit,
  input  logic             we,
  input  logic [SET_W-1:0] wr_set,
  input  logic             wr_bit
);

  logic [NUM_SETS-1:0] bits_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
    end else if (we) begin
      bits_q[wr_set] <= wr_bit;
    end
  end

  assign rd_bit = bits_q[rd_set];

endmodule

// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl
// Lookup and refill controller for the 2-way set-associative data cache.
// Takes one CPU access at a time, compares the tags of both ways, and on a
// miss picks a victim, fetches the 8-word line, streams it into the data
// array and finally writes the new tag/valid into the tags file.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_addr/req_ready  CPU access handshake
//   resp_valid/resp_hit/resp_way  one-cycle completion pulse
//   tf_*                          tags-file read address, write controls and
//                                 registered read data (one-cycle latency)
//   mem_req/mem_addr/mem_ack      line fetch request handshake
//   mem_rvalid/mem_rdata          fill data beats
//   fill_*                        data-array write port
module dcache_miss_ctrl
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_way,
  output logic              tf_we,
  output logic              tf_set_element,
  output logic              tf_valid_in,
  output logic [SET_W-1:0]  tf_set_addr,
  output logic [TAG_W-1:0]  tf_tag_in,
  input  logic [TAG_W-1:0]  tf_tag_out0,
  input  logic [TAG_W-1:0]  tf_tag_out1,
  input  logic              tf_valid_out0,
  input  logic              tf_valid_out1,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              fill_we,
  output logic              fill_way,
  output logic [SET_W-1:0]  fill_set,
  output logic [WORD_W-1:0] fill_word,
  output logic [31:0]       fill_data
);

  miss_state_t       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              victim_q;
  logic [WORD_W-1:0] beat_q;

  logic [TAG_W-1:0]  tag_q;
  logic [SET_W-1:0]  set_q;
  logic              hit0;
  logic              hit1;
  logic              lookup_hit;
  logic              hit_way;
  logic              miss_victim;
  logic              lru_rd;
  logic              lru_we;
  logic              lru_wr_bit;
  logic              last_beat;
  logic              active;

  // The byte/word offset is never needed: fill order comes from the beat
  // counter and the fetch address is line aligned.
  logic              unused_offset_bits;
  assign unused_offset_bits = ^{req_addr[SET_LSB-1:0], addr_q[SET_LSB-1:0]};

  assign tag_q = addr_tag(addr_q);
  assign set_q = addr_set(addr_q);

  // Every outward strobe is gated by rst so a reset in any state is quiet
  // in the very cycle it is asserted, not only after the state register
  // has been cleared.
  assign active = ~rst;

  // Tag compare on the registered tags-file outputs. If both ways ever
  // matched, way 0 is reported.
  assign hit0       = tf_valid_out0 & (tf_tag_out0 == tag_q);
  assign hit1       = tf_valid_out1 & (tf_tag_out1 == tag_q);
  assign lookup_hit = hit0 | hit1;
  assign hit_way    = ~hit0;

  // Victim choice: fill an empty way first, otherwise follow the LRU bit.
  assign miss_victim = ~tf_valid_out0 ? 1'b0 :
                       ~tf_valid_out1 ? 1'b1 : lru_rd;

  assign last_beat = (beat_q == WORD_W'(LINE_WORDS - 1));

  // The LRU bit is pointed at the way that was not just used, both on a
  // hit and when a refilled line is installed.
  assign lru_we     = active & (((state_q == ST_LOOKUP) & lookup_hit) |
                                (state_q == ST_TAG_WR));
  assign lru_wr_bit = (state_q == ST_TAG_WR) ? ~victim_q : ~hit_way;

  lru_bits u_lru_bits (
    .clk    (clk),
    .rst    (rst),
    .rd_set (set_q),
    .rd_bit (lru_rd),
    .we     (lru_we),
    .wr_set (set_q),
    .wr_bit (lru_wr_bit)
  );

  // Main controller. The address is latched on accept and held until the
  // access completes, so mem_addr and the tags-file set stay stable for
  // the whole miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      victim_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (lookup_hit) begin
            state_q <= ST_IDLE;
          end else begin
            victim_q <= miss_victim;
            state_q  <= ST_MISS_REQ;
          end
        end
        ST_MISS_REQ: begin
          if (mem_ack) begin
            beat_q  <= '0;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          // Beats may arrive with gaps; only mem_rvalid advances the line.
          if (mem_rvalid) begin
            beat_q <= beat_q + WORD_W'(1);
            if (last_beat) begin
              state_q <= ST_TAG_WR;
            end
          end
        end
        ST_TAG_WR: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode. In IDLE the tags file is addressed straight from the
  // request so its data is ready in LOOKUP, one cycle after accept.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_hit       = 1'b0;
    resp_way       = 1'b0;
    tf_we          = 1'b0;
    tf_set_element = 1'b0;
    tf_valid_in    = 1'b0;
    tf_set_addr    = '0;
    tf_tag_in      = '0;
    mem_req        = 1'b0;
    mem_addr       = '0;
    fill_we        = 1'b0;
    fill_way       = 1'b0;
    fill_set       = '0;
    fill_word      = '0;
    fill_data      = '0;

    if (active) begin
      tf_set_addr = (state_q == ST_IDLE) ? addr_set(req_addr) : set_q;
      mem_addr    = line_addr(addr_q);
      fill_way    = victim_q;
      fill_set    = set_q;
      fill_word   = beat_q;

      case (state_q)
        ST_IDLE: begin
          req_ready = 1'b1;
        end
        ST_LOOKUP: begin
          if (lookup_hit) begin
            resp_valid = 1'b1;
            resp_hit   = 1'b1;
            resp_way   = hit_way;
          end
        end
        ST_MISS_REQ: begin
          mem_req = 1'b1;
        end
        ST_FILL: begin
          fill_we   = mem_rvalid;
          fill_data = mem_rdata;
        end
        ST_TAG_WR: begin
          tf_we          = 1'b1;
          tf_set_element = victim_q;
          tf_tag_in      = tag_q;
          tf_valid_in    = 1'b1;
          resp_valid     = 1'b1;
          resp_hit       = 1'b0;
          resp_way       = victim_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl
// Directed, table-driven bench for dcache_miss_ctrl. A behavioural tags file
// (registered read, synchronous write, valid cleared by rst) and a scripted
// memory responder surround the DUT. Each table entry is one CPU access with
// its expected hit/way; the miss-side expectations (fetch address, fill
// beats, tag write) are derived from the address inside the bench.
module tb_dcache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_hit;
  logic        resp_way;
  logic        tf_we;
  logic        tf_set_element;
  logic        tf_valid_in;
  logic [6:0]  tf_set_addr;
  logic [12:0] tf_tag_in;
  logic [12:0] tf_tag_out0;
  logic [12:0] tf_tag_out1;
  logic        tf_valid_out0;
  logic        tf_valid_out1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fill_we;
  logic        fill_way;
  logic [6:0]  fill_set;
  logic [2:0]  fill_word;
  logic [31:0] fill_data;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  dcache_miss_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit),
    .resp_way       (resp_way),
    .tf_we          (tf_we),
    .tf_set_element (tf_set_element),
    .tf_valid_in    (tf_valid_in),
    .tf_set_addr    (tf_set_addr),
    .tf_tag_in      (tf_tag_in),
    .tf_tag_out0    (tf_tag_out0),
    .tf_tag_out1    (tf_tag_out1),
    .tf_valid_out0  (tf_valid_out0),
    .tf_valid_out1  (tf_valid_out1),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .fill_we        (fill_we),
    .fill_way       (fill_way),
    .fill_set       (fill_set),
    .fill_word      (fill_word),
    .fill_data      (fill_data)
  );

  // Behavioural tags file: registered read of both ways, write on tf_we,
  // all valid bits cleared while rst is high.
  logic [12:0] tagMem0 [128];
  logic [12:0] tagMem1 [128];
  logic        vldMem0 [128];
  logic        vldMem1 [128];

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 128; s++) begin
        vldMem0[s] <= 1'b0;
        vldMem1[s] <= 1'b0;
      end
    end else if (tf_we) begin
      if (tf_set_element) begin
        tagMem1[tf_set_addr] <= tf_tag_in;
        vldMem1[tf_set_addr] <= tf_valid_in;
      end else begin
        tagMem0[tf_set_addr] <= tf_tag_in;
        vldMem0[tf_set_addr] <= tf_valid_in;
      end
    end
    tf_tag_out0   <= tagMem0[tf_set_addr];
    tf_tag_out1   <= tagMem1[tf_set_addr];
    tf_valid_out0 <= vldMem0[tf_set_addr];
    tf_valid_out1 <= vldMem1[tf_set_addr];
  end

  typedef struct {
    logic [31:0] addr;
    int          ackDelay;
    int          gap;
    logic        expHit;
    logic        expWay;
  } vec_t;

  typedef struct packed {
    logic        acceptReady;
    logic        respSeen;
    logic        hit;
    logic        way;
    int          respCyc;
    int          memReqFirst;
    int          memReqCycles;
    logic [31:0] memAddr;
    logic        memAddrUnstable;
    int          nFill;
    logic        fillErr;
    logic        fillWay;
    int          lastBeatCyc;
    int          nTfWe;
    int          tfWeCyc;
    logic [6:0]  tfSet;
    logic        tfElem;
    logic [12:0] tfTag;
    logic        tfValidIn;
    logic        readyErr;
    logic        aborted;
    logic        abortNoisy;
    logic        timeout;
  } acc_t;

  function automatic logic [31:0] beatData(input logic [31:0] a, input int b);
    return (a & 32'hFFFF_FFE0) ^ 32'hC0DE_0000 ^ (32'(b) * 32'h0101_0101);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One full access. Called and returns at posedge+1 with the DUT in IDLE.
  // Inputs are driven at posedge+1 and outputs sampled at posedge+4.
  // abortAfter >= 0 pulses rst for one cycle once that many beats were sent.
  task automatic applyStimulus(input logic [31:0] addr, input int ackDelay,
                               input int gap, input int abortAfter,
                               output acc_t r);
    int   ackWait;
    int   beat;
    int   gapCnt;
    bit   acked;
    bit   done;
    bit   droveBeat;
    r = '0;
    ackWait = 0;
    beat = 0;
    gapCnt = 0;
    acked = 0;
    done = 0;

    req_valid  = 1'b1;
    req_addr   = addr;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    #3;
    r.acceptReady = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = ~addr;

    for (int cyc = 1; cyc < 300 && !done; cyc++) begin
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
      droveBeat  = 0;
      if (mem_req) begin
        // Stray data while waiting for the ack must be ignored.
        mem_rvalid = 1'b1;
        if (ackWait == ackDelay) begin
          mem_ack = 1'b1;
          acked   = 1;
        end else begin
          ackWait++;
        end
      end else if (acked && beat < 8) begin
        if (abortAfter >= 0 && beat == abortAfter) begin
          rst       = 1'b1;
          r.aborted = 1'b1;
        end else if (gapCnt < gap) begin
          // Stray ack during a gap must be ignored.
          gapCnt++;
          mem_ack = 1'b1;
        end else begin
          mem_rvalid    = 1'b1;
          mem_rdata     = beatData(addr, beat);
          droveBeat     = 1;
          beat++;
          gapCnt        = 0;
          r.lastBeatCyc = cyc;
        end
      end
      #3;
      if (rst) begin
        r.abortNoisy = req_ready | resp_valid | tf_we | fill_we | mem_req;
        done = 1;
      end
      if (req_ready) r.readyErr = 1'b1;
      if (mem_req) begin
        if (r.memReqCycles == 0) begin
          r.memReqFirst = cyc;
          r.memAddr     = mem_addr;
        end else if (mem_addr != r.memAddr) begin
          r.memAddrUnstable = 1'b1;
        end
        r.memReqCycles++;
      end
      if (fill_we) begin
        if (!droveBeat || fill_word != 3'(r.nFill) ||
            fill_data != beatData(addr, r.nFill) || fill_set != addr[11:5])
          r.fillErr = 1'b1;
        if (r.nFill == 0) r.fillWay = fill_way;
        else if (fill_way != r.fillWay) r.fillErr = 1'b1;
        r.nFill++;
      end else if (droveBeat) begin
        r.fillErr = 1'b1;
      end
      if (tf_we) begin
        r.nTfWe++;
        r.tfWeCyc   = cyc;
        r.tfSet     = tf_set_addr;
        r.tfElem    = tf_set_element;
        r.tfTag     = tf_tag_in;
        r.tfValidIn = tf_valid_in;
      end
      if (resp_valid) begin
        r.respSeen = 1'b1;
        r.hit      = resp_hit;
        r.way      = resp_way;
        r.respCyc  = cyc;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) r.timeout = 1'b1;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    rst        = 1'b0;
    req_addr   = 32'h0;
  endtask

  // Full set of checks for one completed (non-aborted) access.
  task automatic checkAccess(input string tag, input vec_t v, input acc_t r);
    checkOutput({tag, " timeout"}, {31'b0, r.timeout}, 32'd0);
    checkOutput({tag, " ready_at_accept"}, {31'b0, r.acceptReady}, 32'd1);
    checkOutput({tag, " resp_seen"}, {31'b0, r.respSeen}, 32'd1);
    checkOutput({tag, " resp_hit"}, {31'b0, r.hit}, {31'b0, v.expHit});
    checkOutput({tag, " resp_way"}, {31'b0, r.way}, {31'b0, v.expWay});
    checkOutput({tag, " ready_low_busy"}, {31'b0, r.readyErr}, 32'd0);
    if (v.expHit) begin
      checkOutput({tag, " hit_latency"}, r.respCyc, 32'd1);
      checkOutput({tag, " hit_no_mem_req"}, r.memReqCycles, 32'd0);
      checkOutput({tag, " hit_no_fill"}, r.nFill, 32'd0);
      checkOutput({tag, " hit_no_tf_we"}, r.nTfWe, 32'd0);
    end else begin
      checkOutput({tag, " mem_req_start"}, r.memReqFirst, 32'd2);
      checkOutput({tag, " mem_req_len"}, r.memReqCycles, 32'(v.ackDelay + 1));
      checkOutput({tag, " mem_addr"}, r.memAddr, v.addr & 32'hFFFF_FFE0);
      checkOutput({tag, " mem_addr_stable"}, {31'b0, r.memAddrUnstable}, 32'd0);
      checkOutput({tag, " fill_beats"}, r.nFill, 32'd8);
      checkOutput({tag, " fill_content"}, {31'b0, r.fillErr}, 32'd0);
      checkOutput({tag, " fill_way"}, {31'b0, r.fillWay}, {31'b0, v.expWay});
      checkOutput({tag, " resp_after_last_beat"}, r.respCyc, 32'(r.lastBeatCyc + 1));
      checkOutput({tag, " tf_we_count"}, r.nTfWe, 32'd1);
      checkOutput({tag, " tf_we_with_resp"}, r.tfWeCyc, r.respCyc);
      checkOutput({tag, " tf_set"}, {25'b0, r.tfSet}, {25'b0, v.addr[11:5]});
      checkOutput({tag, " tf_elem"}, {31'b0, r.tfElem}, {31'b0, v.expWay});
      checkOutput({tag, " tf_tag"}, {19'b0, r.tfTag}, {19'b0, v.addr[24:12]});
      checkOutput({tag, " tf_valid_in"}, {31'b0, r.tfValidIn}, 32'd1);
    end
  endtask

  task automatic checkIdleQuiet(input string tag);
    logic others;
    others = resp_valid | resp_hit | resp_way | tf_we | tf_set_element |
             tf_valid_in | (|tf_set_addr) | (|tf_tag_in) | mem_req |
             (|mem_addr) | fill_we | fill_way | (|fill_set) | (|fill_word) |
             (|fill_data);
    checkOutput({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
    checkOutput({tag, " outputs_zero"}, {31'b0, others}, 32'd0);
  endtask

  vec_t vecs[13];
  acc_t res;
  vec_t hv;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // addr, ackDelay, gap, expHit, expWay
    vecs[0]  = '{32'h0000_1020, 0, 0, 1'b0, 1'b0}; // cold miss, way 0 empty
    vecs[1]  = '{32'h0000_1020, 0, 0, 1'b1, 1'b0}; // hit way 0
    vecs[2]  = '{32'h0000_3020, 0, 0, 1'b0, 1'b1}; // way 1 still empty
    vecs[3]  = '{32'h0000_3020, 0, 0, 1'b1, 1'b1}; // hit way 1, lru -> 0
    vecs[4]  = '{32'h0000_5020, 0, 0, 1'b0, 1'b0}; // both valid, lru = 0
    vecs[5]  = '{32'h0000_1020, 0, 0, 1'b0, 1'b1}; // evicted; lru = 1
    vecs[6]  = '{32'h0000_5020, 0, 0, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_2040, 5, 2, 1'b0, 1'b0}; // slow ack, gapped beats
    vecs[8]  = '{32'hABC0_1FFC, 1, 1, 1'b0, 1'b0}; // top set 127
    vecs[9]  = '{32'hABC0_1FFC, 0, 0, 1'b1, 1'b0};
    vecs[10] = '{32'h5BC0_1FE4, 0, 0, 1'b1, 1'b0}; // bits above tag ignored
    vecs[11] = '{32'h0000_103C, 0, 0, 1'b1, 1'b1}; // other word, same line
    vecs[12] = '{32'h0000_3020, 2, 0, 1'b0, 1'b0}; // lru = 0 after hit way1

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    @(posedge clk);
    @(posedge clk);
    #4;
    checkOutput("reset req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("reset outputs_zero",
                {31'b0, resp_valid | tf_we | mem_req | fill_we | (|mem_addr) |
                        (|tf_set_addr) | (|fill_word)}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    checkIdleQuiet("post_reset");
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].ackDelay, vecs[i].gap, -1, res);
      checkAccess($sformatf("vec%0d", i), vecs[i], res);
    end

    // Reset in the middle of a fill after three beats.
    applyStimulus(32'h0000_7060, 0, 0, 3, res);
    checkOutput("abort taken", {31'b0, res.aborted}, 32'd1);
    checkOutput("abort beats_before", res.nFill, 32'd3);
    checkOutput("abort quiet_in_rst", {31'b0, res.abortNoisy}, 32'd0);
    checkOutput("abort no_tf_we", res.nTfWe, 32'd0);
    checkOutput("abort no_resp", {31'b0, res.respSeen}, 32'd0);
    checkOutput("abort fill_content", {31'b0, res.fillErr}, 32'd0);
    #3;
    checkIdleQuiet("after_abort");
    @(posedge clk);
    #1;

    // Same line again must miss, and set 1 has lost its contents.
    hv = '{32'h0000_7060, 0, 0, 1'b0, 1'b0};
    applyStimulus(hv.addr, hv.ackDelay, hv.gap, -1, res);
    checkAccess("reaccess", hv, res);
    hv = '{32'h0000_1020, 0, 0, 1'b0, 1'b0};
    applyStimulus(hv.addr, hv.ackDelay, hv.gap, -1, res);
    checkAccess("set1_cleared", hv, res);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
